// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter sharing one combinational FP ALU between two valid/ready requesters.
// Define FPALU_ARB_STATS_EN to add saturating per-requester grant counters.
module fp_alu_arbiter #(
    parameter int W       = 32,
    parameter int ALU_LAT = 1
`ifdef FPALU_ARB_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic             req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [W-1:0]     rsp0_result,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp1_result,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic             alu_select,
    input  logic [W-1:0]     alu_result,
    output logic             busy
`ifdef FPALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_count,
    output logic [CNT_W-1:0] grant1_count
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic           alu_sel_q, alu_sel_d;
    logic           rsp0_valid_q, rsp0_valid_d;
    logic           rsp1_valid_q, rsp1_valid_d;
    logic [W-1:0]   rsp0_result_q, rsp0_result_d;
    logic [W-1:0]   rsp1_result_q, rsp1_result_d;
    logic           winner;
    logic           owner_rsp_ready;

    // Contest goes to the requester that did not win last; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = req1_valid;
        end
    end

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready   = ~winner;
                    req1_ready   = winner;
                    owner_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = LAT_M1;
                    alu_a_d      = winner ? req1_a  : req0_a;
                    alu_b_d      = winner ? req1_b  : req0_b;
                    alu_sel_d    = winner ? req1_op : req0_op;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (owner_q) begin
                        rsp1_valid_d  = 1'b1;
                        rsp1_result_d = alu_result;
                    end else begin
                        rsp0_valid_d  = 1'b1;
                        rsp0_result_d = alu_result;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_select  = alu_sel_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign busy        = (state_q != IDLE);

`ifdef FPALU_ARB_STATS_EN
    logic [1:0]       grant_hs;
    logic [CNT_W-1:0] grant_cnt_q [2];

    assign grant_hs = {req1_ready, req0_ready};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    grant_cnt_q[gi] <= '0;
                end else if (grant_hs[gi] && (grant_cnt_q[gi] != {CNT_W{1'b1}})) begin
                    grant_cnt_q[gi] <= grant_cnt_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign grant0_count = grant_cnt_q[0];
    assign grant1_count = grant_cnt_q[1];
`endif

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed testbench for fp_alu_arbiter with a table-driven ALU model.
module tb_fp_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_select, busy;
`ifdef FPALU_ARB_STATS_EN
    logic [15:0] grant0_count, grant1_count;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed IEEE-754 results for every operand pair the bench issues.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic sel);
        if (!sel && a == 32'h3f800000 && b == 32'h40000000) return 32'h40000000;
        if ( sel && a == 32'h3f800000 && b == 32'h3f800000) return 32'h40000000;
        if (!sel && a == 32'hbf800000 && b == 32'h40000000) return 32'hc0000000;
        if ( sel && a == 32'h3f800000 && b == 32'h40000000) return 32'h40400000;
        if ( sel && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        if (!sel && a == 32'h40400000 && b == 32'h40000000) return 32'h40c00000;
        return 32'h7fc00000;
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_select);

    fp_alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_result(alu_result),
        .busy(busy)
`ifdef FPALU_ARB_STATS_EN
        , .grant0_count(grant0_count), .grant1_count(grant1_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef FPALU_ARB_STATS_EN
    task automatic do_op(input logic who);
        int n;
        n = 0;
        if (who) begin req1_valid = 1; req1_a = 32'h3f800000; req1_b = 32'h40000000; req1_op = 0; end
        else     begin req0_valid = 1; req0_a = 32'h3f800000; req0_b = 32'h40000000; req0_op = 0; end
        #1;
        while (!(who ? req1_ready : req0_ready) && n < 10) begin tick(); #1; n++; end
        chk("stats_grant", 32'(who ? req1_ready : req0_ready), 32'd1);
        tick();
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        n = 0;
        #1;
        while (!(who ? rsp1_valid : rsp0_valid) && n < 10) begin tick(); #1; n++; end
        chk("stats_rsp", who ? rsp1_result : rsp0_result, 32'h40000000);
        tick();
        rsp0_ready = 0; rsp1_ready = 0;
    endtask
`endif

    logic [31:0] t4_a   [3];
    logic [31:0] t4_b   [3];
    logic        t4_op  [3];
    logic [31:0] t4_exp [3];

    initial begin
        int n;
        int prev;
        t4_a[0] = 32'h40000000; t4_b[0] = 32'h40000000; t4_op[0] = 1; t4_exp[0] = 32'h40800000;
        t4_a[1] = 32'h3f800000; t4_b[1] = 32'h40000000; t4_op[1] = 1; t4_exp[1] = 32'h40400000;
        t4_a[2] = 32'h40400000; t4_b[2] = 32'h40000000; t4_op[2] = 0; t4_exp[2] = 32'h40c00000;

        rst = 1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", 32'(alu_select), 0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
        chk("rst_rsp0_result", rsp0_result, 0);
        chk("rst_rsp1_result", rsp1_result, 0);
        rst = 0;
        tick();

        // Single multiply from requester 0
        req0_valid = 1; req0_a = 32'h3f800000; req0_b = 32'h40000000; req0_op = 0;
        #1;
        chk("t1_req0_ready", 32'(req0_ready), 1);
        chk("t1_req1_ready", 32'(req1_ready), 0);
        tick();
        req0_valid = 0; req0_a = 32'h12345678;
        #1;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_alu_a", alu_a, 32'h3f800000);
        chk("t1_alu_b", alu_b, 32'h40000000);
        chk("t1_alu_sel", 32'(alu_select), 0);
        chk("t1_wait_ready", 32'(req0_ready), 0);
        chk("t1_early_valid", 32'(rsp0_valid), 0);
        tick();
        chk("t1_rsp0_valid", 32'(rsp0_valid), 1);
        chk("t1_rsp0_result", rsp0_result, 32'h40000000);
        chk("t1_rsp1_valid", 32'(rsp1_valid), 0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        #1;
        chk("t1_done_valid", 32'(rsp0_valid), 0);
        chk("t1_done_busy", 32'(busy), 0);
        chk("t1_hold_alu_a", alu_a, 32'h3f800000);

        // Simultaneous requests right after reset
        rst = 1;
        tick();
        rst = 0;
        req0_valid = 1; req0_a = 32'h3f800000; req0_b = 32'h3f800000; req0_op = 1;
        req1_valid = 1; req1_a = 32'hbf800000; req1_b = 32'h40000000; req1_op = 0;
        #1;
        chk("t2_req0_ready", 32'(req0_ready), 1);
        chk("t2_req1_ready", 32'(req1_ready), 0);
        tick();
        req0_valid = 0;
        #1;
        chk("t2_req1_blocked", 32'(req1_ready), 0);
        chk("t2_alu_sel", 32'(alu_select), 1);
        tick();
        chk("t2_rsp0_valid", 32'(rsp0_valid), 1);
        chk("t2_rsp0_result", rsp0_result, 32'h40000000);
        chk("t2_rsp1_idle", 32'(rsp1_valid), 0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        #1;
        chk("t2_req1_ready", 32'(req1_ready), 1);
        tick();
        req1_valid = 0;
        #1;
        chk("t2_alu_a", alu_a, 32'hbf800000);
        chk("t2_alu_sel_mul", 32'(alu_select), 0);
        tick();
        chk("t2_rsp1_valid", 32'(rsp1_valid), 1);
        chk("t2_rsp1_result", rsp1_result, 32'hc0000000);
        chk("t2_rsp0_quiet", 32'(rsp0_valid), 0);

        // Response backpressure on requester 1 while requester 0 waits
        req0_valid = 1; req0_a = 32'h3f800000; req0_b = 32'h40000000; req0_op = 1;
        rsp0_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_rsp1_valid", 32'(rsp1_valid), 1);
            chk("t3_rsp1_result", rsp1_result, 32'hc0000000);
            chk("t3_req0_ready", 32'(req0_ready), 0);
            chk("t3_rsp0_ignored", 32'(rsp0_valid), 0);
            tick();
        end
        rsp0_ready = 0;
        rsp1_ready = 1;
        #1;
        chk("t3_req0_still_low", 32'(req0_ready), 0);
        tick();
        rsp1_ready = 0;
        #1;
        chk("t3_idle_busy", 32'(busy), 0);
        chk("t3_rsp1_cleared", 32'(rsp1_valid), 0);
        chk("t3_req0_granted", 32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        tick();
        chk("t3_rsp0_valid", 32'(rsp0_valid), 1);
        chk("t3_rsp0_result", rsp0_result, 32'h40400000);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;

        // Lone requester 1 served back to back
        rsp1_ready = 1;
        req1_valid = 1; req1_a = t4_a[0]; req1_b = t4_b[0]; req1_op = t4_op[0];
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            #1;
            while (!req1_ready && n < 10) begin tick(); #1; n++; end
            chk("t4_grant", 32'(req1_ready), 1);
            if (k > 0) chk("t4_interval", 32'(cyc - prev), 32'd3);
            prev = cyc;
            tick();
            if (k < 2) begin
                req1_a = t4_a[k+1]; req1_b = t4_b[k+1]; req1_op = t4_op[k+1];
            end else begin
                req1_valid = 0;
            end
            n = 0;
            #1;
            while (!rsp1_valid && n < 10) begin tick(); #1; n++; end
            chk("t4_rsp1_result", rsp1_result, t4_exp[k]);
            chk("t4_rsp0_quiet", 32'(rsp0_valid), 0);
            tick();
        end
        rsp1_ready = 0;

        // Reset while the operation is in WAIT
        req0_valid = 1; req0_a = 32'h3f800000; req0_b = 32'h40000000; req0_op = 0;
        #1;
        chk("t5_req0_ready", 32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        #1;
        chk("t5_busy_wait", 32'(busy), 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_alu_a", alu_a, 0);
        chk("t5_alu_b", alu_b, 0);
        chk("t5_alu_sel", 32'(alu_select), 0);
        chk("t5_rsp0_valid", 32'(rsp0_valid), 0);
        chk("t5_rsp1_valid", 32'(rsp1_valid), 0);
        chk("t5_rsp0_result", rsp0_result, 0);
        chk("t5_rsp1_result", rsp1_result, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        end

`ifdef FPALU_ARB_STATS_EN
        for (int i = 0; i < 4; i++) do_op(1'b0);
        for (int i = 0; i < 3; i++) do_op(1'b1);
        #1;
        chk("st_grant0", 32'(grant0_count), 32'd4);
        chk("st_grant1", 32'(grant1_count), 32'd3);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("st_grant0_rst", 32'(grant0_count), 0);
        chk("st_grant1_rst", 32'(grant1_count), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_alu_arbiter.md
Name: fp_alu_arbiter

Overview:
- Shares one combinational FP ALU (IEEE-754 single; `select` 0 = multiply, 1 = add) between two requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin grant. Operands are registered into the ALU, the result is captured after a programmable settle time, then returned to the granted requester.
- Sits between the two datapath clients and the ALU instance in the FPALU top.

Parameters:
- W, 32, operand/result width (IEEE-754 single).
- ALU_LAT, 1, cycles operands are held on the ALU before the result is sampled; legal range 1..15.
- CNT_W, 16, width of the grant statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  request 0 accepted this cycle.
- req0_a  in  W  operand A.
- req0_b  in  W  operand B.
- req0_op  in  1  0 = multiply, 1 = add.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_result  out  W  result for requester 0.
- rsp1_valid, rsp1_ready, rsp1_result: same as requester 0, for requester 1.
- alu_a  out  W  registered ALU operand A.
- alu_b  out  W  registered ALU operand B.
- alu_select  out  1  registered ALU op select.
- alu_result  in  W  ALU combinational result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: clk and rst as above; reset is synchronous, active-high.
  - Registered outputs clear to 0: alu_a, alu_b, alu_select, rsp*_valid, rsp*_result.
  - busy = 0. State = IDLE. last_grant = 1, so requester 0 wins the first contest.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Winner = the only valid requester; if both are valid, the one not equal to last_grant.
  - reqN_ready = (state == IDLE) && winner == N && reqN_valid. This is combinational; the handshake completes in that cycle.
  - On handshake: latch a/b/op into alu_a/alu_b/alu_select, record owner, set last_grant = owner, load wait counter with ALU_LAT-1, go to WAIT.
  - With no valid requester: stay in IDLE; both ready low.
- WAIT:
  - Counter decrements each cycle.
  - At counter == 0: capture alu_result into the result register, go to RESP.
  - Operands are held stable for exactly ALU_LAT cycles before capture.
- RESP:
  - rsp<owner>_valid = 1 and rsp<owner>_result = captured value; the other rsp_valid stays 0.
  - Valid and result stay stable until rsp<owner>_ready = 1; that cycle is the handshake, and the next state is IDLE.
  - reqN_ready stays low throughout WAIT and RESP. New requests wait; no request is dropped.
- Latency:
  - Request handshake to rsp_valid = ALU_LAT+1 cycles.
  - Minimum issue interval = ALU_LAT+2 cycles with zero response backpressure.
- alu_a/alu_b/alu_select keep their last values in IDLE; there is no glitch toggling.
- Arbitration:
  - Strict alternation when both requesters stay valid.
  - A lone requester is served back-to-back regardless of last_grant.
- Reset mid-operation: the operation in flight is abandoned, no response is issued, and all state returns to reset values on the next edge.
- Invalid response cycles: rsp_ready asserted while rsp_valid is low is ignored.
- Operand changes: requester operand changes after its handshake have no effect on alu_a/alu_b.

Optional Feature:
- Macro: FPALU_ARB_STATS_EN.
- When defined:
  - Adds outputs grant0_count and grant1_count (CNT_W, out).
  - Each increments on its requester's request handshake and saturates at all-ones.
  - Both clear on rst.
- When not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Req0 multiply, a=3f800000, b=40000000, op=0, ALU_LAT=1 -> req0_ready high in the handshake cycle; rsp0_valid 2 cycles later with 40000000; rsp1_valid stays 0.
- Req0 and req1 valid in the same cycle after reset: req0 add 3f800000+3f800000, req1 multiply bf800000*40000000 -> req0 is granted first and receives 40000000; req1 is granted next and receives c0000000.
- rsp1_ready held low for 5 cycles while requester 1 has a result pending -> rsp1_valid and rsp1_result stay stable; req0_ready stays low; one cycle after rsp1_ready rises, the state is IDLE and req0 can be granted.
- Req1 valid continuously for 3 ops, req0 idle -> three back-to-back grants to req1, each ALU_LAT+2 cycles apart.
- Assert rst during WAIT -> no rsp_valid is ever asserted for that op; busy=0 and all outputs are 0 the cycle after rst.
- FPALU_ARB_STATS_EN defined, 4 grants to req0 and 3 to req1 -> grant0_count=4, grant1_count=3; rst clears both to 0.
